axi4_dual_req_arbiter: RTL and testbench

Shares one AXI4 master port between two simple requesters, for example a CPU load/store unit and a DMA, in front of the on-chip AXI4 RAM slave.
Each requester issues single-word read or write commands. The block arbitrates round-robin and sequences each command as one single-beat AXI4 transaction, with exactly one transaction outstanding at a time.
It returns a one-cycle ack, read data and an error flag to the requester that was granted.

---
 rtl/axi4_dual_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi4_dual_req_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_dual_req_arbiter.sv
// rtl/axi4_dual_req_arbiter.sv - round-robin arbiter sharing one single-beat AXI4 master between two requesters
module axi4_dual_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RDATA,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_last;
  logic                  r_grant;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_grant;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [ID_WIDTH-1:0]   w_id;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;

  // On a tie the requester that did not win last time is served.
  assign w_grant     = req[1] & (~req[0] | ~r_last);
  assign w_sel_we    = w_grant ? we[1] : we[0];
  assign w_sel_addr  = w_grant ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
  assign w_sel_wdata = w_grant ? wdata[DATA_WIDTH +: DATA_WIDTH] : wdata[0 +: DATA_WIDTH];
  assign w_id        = ID_WIDTH'(r_grant);

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_w_hs  = m_axi_wvalid & m_axi_wready;
  assign w_ar_hs = m_axi_arvalid & m_axi_arready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant   <= w_grant;
            r_last    <= w_grant;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= w_sel_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // The two handshakes may land in the same cycle or in either order.
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) r_state <= S_WRESP;
        end
        S_WRESP: begin
          if (m_axi_bvalid) begin
            r_err   <= (m_axi_bresp != 2'b00) || (m_axi_bid != w_id);
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          if (w_ar_hs) r_state <= S_RDATA;
        end
        S_RDATA: begin
          if (m_axi_rvalid) begin
            r_rdata <= m_axi_rdata;
            r_err   <= (m_axi_rresp != 2'b00) || (m_axi_rid != w_id) || !m_axi_rlast;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack   = (r_state == S_DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rdata = r_rdata;
  assign err   = r_err;

  assign m_axi_awid    = w_id;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (r_state == S_WRITE) & ~r_aw_done;

  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = (r_state == S_WRITE) & ~r_w_done;

  assign m_axi_bready  = (r_state == S_WRESP);

  assign m_axi_arid    = w_id;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (r_state == S_READ);

  assign m_axi_rready  = (r_state == S_RDATA);

endmodule

// File: tb/tb_axi4_dual_req_arbiter.sv
// tb/tb_axi4_dual_req_arbiter.sv - scoreboard bench with a reactive AXI slave for axi4_dual_req_arbiter
module tb_axi4_dual_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic           aclk    = 1'b0;
  logic           aresetn = 1'b0;
  logic [1:0]     req     = 2'b00;
  logic [1:0]     we      = 2'b00;
  logic [2*AW-1:0] addr   = '0;
  logic [2*DW-1:0] wdata  = '0;
  logic [1:0]     ack;
  logic [DW-1:0]  rdata;
  logic           err;

  logic [IW-1:0]  m_axi_awid, m_axi_arid;
  logic [AW-1:0]  m_axi_awaddr, m_axi_araddr;
  logic [7:0]     m_axi_awlen, m_axi_arlen;
  logic [2:0]     m_axi_awsize, m_axi_arsize;
  logic [1:0]     m_axi_awburst, m_axi_arburst;
  logic           m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [DW-1:0]  m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;

  logic           m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic [IW-1:0]  m_axi_bid = '0, m_axi_rid = '0;
  logic [1:0]     m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic           m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
  logic [DW-1:0]  m_axi_rdata = '0;

  always #5 aclk = ~aclk;

  axi4_dual_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    logic [1:0]    ack;
    logic          is_rd;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  // etype: 0 clean, 1 SLVERR response, 2 wrong id, 3 missing rlast (reads only)
  typedef struct {
    logic          is_wr;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            etype;
  } axi_t;

  exp_t exp_q[$];
  axi_t axi_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int   slave_mode = 0;     // 0 random readies/latency, 1 always ready, 2 awready low for 3 cycles
  logic r_hold     = 1'b0;
  logic model_last = 1'b1;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: predicts grant order from the round-robin rule and the
  // expected completion of each command against a flat word memory.
  task automatic model_round(input logic [1:0] mask, input logic [1:0] wev,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input int e0, input int e1);
    int order[$];
    if (mask == 2'b11) begin
      if (model_last) begin order.push_back(0); order.push_back(1); end
      else            begin order.push_back(1); order.push_back(0); end
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    foreach (order[k]) begin
      int            i;
      exp_t          x;
      axi_t          t;
      logic [AW-1:0] a;
      i = order[k];
      a = (i == 1) ? a1 : a0;
      model_last = (i == 1);
      t.is_wr = wev[i];
      t.id    = (i == 1) ? IW'(1) : IW'(0);
      t.addr  = a;
      t.data  = (i == 1) ? d1 : d0;
      t.etype = (i == 1) ? e1 : e0;
      x.ack   = (i == 1) ? 2'b10 : 2'b01;
      x.err   = (t.etype != 0);
      x.is_rd = !wev[i];
      x.rdata = ref_mem.exists(a) ? ref_mem[a] : '0;
      if (wev[i]) ref_mem[a] = t.data;
      exp_q.push_back(x);
      axi_q.push_back(t);
    end
  endtask

  task automatic run_round(input logic [1:0] mask, input logic [1:0] wev,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input int e0, input int e1, output int lat);
    logic [1:0] pending;
    int         cyc;
    model_round(mask, wev, a0, a1, d0, d1, e0, e1);
    @(negedge aclk);
    req = mask; we = wev; addr = {a1, a0}; wdata = {d1, d0};
    pending = mask; cyc = 0; lat = -1;
    while (pending != 2'b00 && cyc < 400) begin
      @(negedge aclk);
      cyc++;
      if ((ack & pending) != 2'b00) begin
        if (lat < 0) lat = cyc;
        pending = pending & ~ack;
        req     = req & ~ack;
      end
    end
    check("round_completed", {62'd0, pending}, 64'd0);
    req = 2'b00;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge aclk);
    aresetn = 1'b0; req = 2'b00;
    repeat (cycles) @(negedge aclk);
    check("reset_ctrl_outputs",
          {57'd0, ack, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
    check("reset_rdata", {32'd0, rdata}, 64'd0);
    @(negedge aclk);
    exp_q.delete(); axi_q.delete();
    model_last = 1'b1;
    aresetn = 1'b1;
  endtask

  // Reactive slave. Readies are set on the falling edge, so a valid seen at
  // that moment together with the new ready is a handshake at the next rise.
  initial begin : slave_proc
    logic s_aw_have, s_w_have, s_ar_have, s_b_hs, s_r_hs, busy;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [IW-1:0] s_awid, s_arid;
    logic [DW-1:0] s_wdata;
    int   s_aw_cnt, s_w_cnt, s_aw_wait;
    axi_t t;
    s_aw_have = 0; s_w_have = 0; s_ar_have = 0; s_b_hs = 0; s_r_hs = 0;
    s_awaddr = '0; s_araddr = '0; s_awid = '0; s_arid = '0; s_wdata = '0;
    s_aw_cnt = 0; s_w_cnt = 0; s_aw_wait = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        s_aw_have = 0; s_w_have = 0; s_ar_have = 0; s_b_hs = 0; s_r_hs = 0;
        s_aw_cnt = 0; s_w_cnt = 0; s_aw_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end else begin
        if (s_b_hs) m_axi_bvalid = 1'b0;
        if (s_r_hs) m_axi_rvalid = 1'b0;
        if (s_aw_have && s_w_have && !m_axi_bvalid && (slave_mode != 0 || $urandom_range(0, 2) != 0)) begin
          t.is_wr = 1'b1; t.id = s_awid; t.addr = s_awaddr; t.data = s_wdata; t.etype = 0;
          check("axi_write_expected", {63'd0, (axi_q.size() != 0)}, 64'd1);
          if (axi_q.size() != 0) t = axi_q.pop_front();
          check("axi_kind_write", {63'd0, t.is_wr}, 64'd1);
          check("awaddr", {32'd0, s_awaddr}, {32'd0, t.addr});
          check("awid", {60'd0, s_awid}, {60'd0, t.id});
          check("wdata", {32'd0, s_wdata}, {32'd0, t.data});
          check("aw_handshakes", s_aw_cnt, 1);
          check("w_handshakes", s_w_cnt, 1);
          slv_mem[s_awaddr] = s_wdata;
          m_axi_bid    = (t.etype == 2) ? (s_awid ^ IW'(1)) : s_awid;
          m_axi_bresp  = (t.etype == 1) ? 2'b10 : 2'b00;
          m_axi_bvalid = 1'b1;
          s_aw_have = 0; s_w_have = 0; s_aw_cnt = 0; s_w_cnt = 0; s_aw_wait = 0;
        end
        if (s_ar_have && !m_axi_rvalid && !r_hold && (slave_mode != 0 || $urandom_range(0, 2) != 0)) begin
          t.is_wr = 1'b0; t.id = s_arid; t.addr = s_araddr; t.data = '0; t.etype = 0;
          check("axi_read_expected", {63'd0, (axi_q.size() != 0)}, 64'd1);
          if (axi_q.size() != 0) t = axi_q.pop_front();
          check("axi_kind_read", {63'd0, t.is_wr}, 64'd0);
          check("araddr", {32'd0, s_araddr}, {32'd0, t.addr});
          check("arid", {60'd0, s_arid}, {60'd0, t.id});
          m_axi_rdata  = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : '0;
          m_axi_rid    = (t.etype == 2) ? (s_arid ^ IW'(1)) : s_arid;
          m_axi_rresp  = (t.etype == 1) ? 2'b10 : 2'b00;
          m_axi_rlast  = (t.etype != 3);
          m_axi_rvalid = 1'b1;
          s_ar_have = 0;
        end
        case (slave_mode)
          1: begin m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1; end
          2: begin m_axi_awready = (s_aw_wait >= 3); m_axi_wready = 1; m_axi_arready = 1; end
          default: begin
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = 1'($urandom_range(0, 1));
            m_axi_arready = 1'($urandom_range(0, 1));
          end
        endcase
        busy = m_axi_bvalid | m_axi_rvalid | (s_aw_have & s_w_have) | s_ar_have;
        if (m_axi_awvalid | m_axi_wvalid | m_axi_arvalid)
          check("single_outstanding", {63'd0, busy}, 64'd0);
        s_b_hs = m_axi_bvalid & m_axi_bready;
        s_r_hs = m_axi_rvalid & m_axi_rready;
        if (m_axi_awvalid && !m_axi_awready) s_aw_wait++;
        if (m_axi_awvalid && m_axi_awready) begin
          s_aw_have = 1; s_awaddr = m_axi_awaddr; s_awid = m_axi_awid; s_aw_cnt++;
          check("aw_constants", {51'd0, m_axi_awlen, m_axi_awsize, m_axi_awburst}, {51'd0, 8'd0, 3'd2, 2'b01});
        end
        if (m_axi_wvalid && m_axi_wready) begin
          s_w_have = 1; s_wdata = m_axi_wdata; s_w_cnt++;
          check("w_constants", {59'd0, m_axi_wstrb, m_axi_wlast}, {59'd0, 4'hF, 1'b1});
        end
        if (m_axi_arvalid && m_axi_arready) begin
          s_ar_have = 1; s_araddr = m_axi_araddr; s_arid = m_axi_arid;
          check("ar_constants", {51'd0, m_axi_arlen, m_axi_arsize, m_axi_arburst}, {51'd0, 8'd0, 3'd2, 2'b01});
        end
      end
    end
  end

  initial begin : monitor_proc
    exp_t x;
    forever begin
      @(negedge aclk);
      if (aresetn && ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {62'd0, ack}, 64'd0);
        end else begin
          x = exp_q.pop_front();
          check("ack", {62'd0, ack}, {62'd0, x.ack});
          check("err", {63'd0, err}, {63'd0, x.err});
          if (x.is_rd) check("rdata", {32'd0, rdata}, {32'd0, x.rdata});
        end
      end
    end
  end

  initial begin : stim_proc
    int lat;
    int cyc;
    do_reset(3);

    slave_mode = 1;
    run_round(2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, lat);
    check("write_latency", lat + 1, 4);
    run_round(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0, lat);
    check("read_latency", lat + 1, 4);

    for (int r = 0; r < 2; r++)
      run_round(2'b11, 2'b11, 32'h20 + 32'(r * 8), 32'h24 + 32'(r * 8), $urandom, $urandom, 0, 0, lat);

    slave_mode = 2;
    run_round(2'b01, 2'b01, 32'h30, 32'h0, 32'hA5A5_0001, 32'h0, 0, 0, lat);
    run_round(2'b10, 2'b10, 32'h0, 32'h34, 32'h0, 32'h5A5A_0002, 0, 0, lat);

    slave_mode = 1;
    run_round(2'b10, 2'b10, 32'h0, 32'h38, 32'h0, 32'h1234_5678, 0, 1, lat);
    run_round(2'b10, 2'b00, 32'h0, 32'h38, 32'h0, 32'h0, 0, 0, lat);

    slave_mode = 0;
    for (int r = 0; r < 40; r++) begin
      logic [1:0]    mask, wev;
      logic [AW-1:0] a0, a1;
      int            e0, e1;
      mask = 2'($urandom_range(1, 3));
      wev  = 2'($urandom_range(0, 3));
      a0   = 32'($urandom_range(0, 15)) << 2;
      a1   = 32'($urandom_range(0, 15)) << 2;
      e0   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, wev[0] ? 2 : 3) : 0;
      e1   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, wev[1] ? 2 : 3) : 0;
      run_round(mask, wev, a0, a1, $urandom, $urandom, e0, e1, lat);
    end

    slave_mode = 1;
    r_hold = 1'b1;
    @(negedge aclk);
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h10};
    cyc = 0;
    while (!m_axi_rready && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    check("reached_rdata", {63'd0, m_axi_rready}, 64'd1);
    aresetn = 1'b0; req = 2'b00;
    @(negedge aclk);
    check("midreset_outputs", {59'd0, m_axi_arvalid, m_axi_rready, ack, m_axi_awvalid}, 64'd0);
    check("midreset_err", {63'd0, err}, 64'd0);
    @(negedge aclk);
    exp_q.delete(); axi_q.delete();
    model_last = 1'b1;
    r_hold = 1'b0;
    aresetn = 1'b1;
    run_round(2'b10, 2'b00, 32'h0, 32'h10, 32'h0, 32'h0, 0, 0, lat);

    do_reset(2);
    run_round(2'b11, 2'b00, 32'h10, 32'h30, 32'h0, 32'h0, 0, 0, lat);

    repeat (5) @(negedge aclk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
